// File: rtl/id_stage_pipe.sv
// Decode stage: instruction decode, register file, load-use hazard detection and ID/EX register.
// Optional WB_BYPASS_EN: same-cycle writeback data is forwarded into the register file read.
`timescale 1ns/1ps
module id_stage_pipe #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [RW-1:0]   ex_rs1,
  output logic [RW-1:0]   ex_rs2,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_is_load
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            is_load;
  } id_ex_t;

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            use_rs1, use_rs2, is_load;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            hazard, adv;
  logic [XLEN-1:0] rf [NREG];
  id_ex_t          dec, ex_q;

  assign opcode  = if_instr[6:0];
  assign rs1     = RW'(if_instr[19:15]);
  assign rs2     = RW'(if_instr[24:20]);
  assign rd      = RW'(if_instr[11:7]);
  assign is_load = (opcode == OP_LOAD);
  assign use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign use_rs2 = (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP);

  always_comb begin
    imm32 = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {if_instr[31:12], 12'h000};
      OP_JAL:    imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  // Entry 0 is never written, but reads still mask it so x0 is hard-wired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : rf[rs1];
    rs2_data = (rs2 == '0) ? '0 : rf[rs2];
`ifdef WB_BYPASS_EN
    if (wb_we && wb_rd != '0 && wb_rd == rs1) rs1_data = wb_data;
    if (wb_we && wb_rd != '0 && wb_rd == rs2) rs2_data = wb_data;
`endif
  end

  assign hazard = if_valid && ex_valid && ex_q.is_load && (ex_q.rd != '0) &&
                  ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
  assign adv      = !ex_valid || ex_ready;
  assign id_ready = adv && !hazard && !flush;

  assign dec = '{pc: if_pc, instr: if_instr, imm: imm, rs1_data: rs1_data,
                 rs2_data: rs2_data, rs1: rs1, rs2: rs2, rd: rd, is_load: is_load};

  // Flush wins over everything; a hazard leaves a bubble while IF holds its instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= if_valid && !hazard;
      if (if_valid && !hazard) ex_q <= dec;
    end
  end

  assign ex_pc       = ex_q.pc;
  assign ex_instr    = ex_q.instr;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_is_load  = ex_q.is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, decode, load-use bubble, backpressure, flush, writeback, immediates.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 0, rst = 0;
  logic            if_valid = 0, flush = 0, wb_we = 0, ex_ready = 0;
  logic [XLEN-1:0] if_pc = '0, wb_data = '0;
  logic [31:0]     if_instr = '0;
  logic [RW-1:0]   wb_rd = '0;
  logic            id_ready, ex_valid, ex_is_load;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [31:0]     ex_instr;
  logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage_pipe #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0; #3;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%h exp=0", ex_valid); end
    n_checks++; if (ex_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", ex_pc); end
    n_checks++; if (ex_instr !== 32'h0 || ex_imm !== 32'h0) begin n_fail++; $display("FAIL reset_payload instr=%h imm=%h exp=0", ex_instr, ex_imm); end
    step(); rst = 1; step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%h exp=0", ex_valid); end
  endtask

  task automatic test_decode();
    if_valid = 1; if_instr = 32'h00500093; if_pc = 32'h100; ex_ready = 1; #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL decode_id_ready got=%h exp=1", id_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL decode_valid got=%h exp=1", ex_valid); end
    n_checks++; if (ex_imm !== 32'd5) begin n_fail++; $display("FAIL decode_imm got=%h exp=5", ex_imm); end
    n_checks++; if (ex_rd !== 5'd1) begin n_fail++; $display("FAIL decode_rd got=%h exp=1", ex_rd); end
    n_checks++; if (ex_rs1_data !== 32'h0) begin n_fail++; $display("FAIL decode_rs1_data got=%h exp=0", ex_rs1_data); end
    n_checks++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL decode_pc got=%h exp=100", ex_pc); end
    n_checks++; if (ex_is_load !== 1'b0) begin n_fail++; $display("FAIL decode_is_load got=%h exp=0", ex_is_load); end
    if_valid = 0; step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%h exp=0", ex_valid); end
  endtask

  task automatic test_load_use();
    wb_we = 1; wb_rd = 5'd1; wb_data = 32'h11; step();
    wb_rd = 5'd2; wb_data = 32'h22; step();
    wb_we = 0;
    if_valid = 1; if_instr = 32'h00002103; if_pc = 32'h200; step();   // lw x2,0(x0)
    n_checks++; if (ex_is_load !== 1'b1 || ex_rd !== 5'd2) begin n_fail++; $display("FAIL lu_load load=%h rd=%h exp=1/2", ex_is_load, ex_rd); end
    if_instr = 32'h001101B3; if_pc = 32'h204; #1;                     // add x3,x2,x1
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall got=%h exp=0", id_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%h exp=0", ex_valid); end
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_resume got=%h exp=1", id_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin n_fail++; $display("FAIL lu_enter valid=%h pc=%h exp=1/204", ex_valid, ex_pc); end
    n_checks++; if (ex_rs1_data !== 32'h22 || ex_rs2_data !== 32'h11) begin n_fail++; $display("FAIL lu_operands rs1=%h rs2=%h exp=22/11", ex_rs1_data, ex_rs2_data); end
    n_checks++; if (ex_rs1 !== 5'd2 || ex_rs2 !== 5'd1 || ex_rd !== 5'd3) begin n_fail++; $display("FAIL lu_idx rs1=%h rs2=%h rd=%h exp=2/1/3", ex_rs1, ex_rs2, ex_rd); end
  endtask

  task automatic test_backpressure();
    ex_ready = 0; if_instr = 32'h00700213; if_pc = 32'h208;          // addi x4,x0,7
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%h exp=0", i, id_ready); end
      step();
      n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_instr !== 32'h001101B3)
        begin n_fail++; $display("FAIL bp_hold[%0d] valid=%h pc=%h instr=%h exp=1/204/001101b3", i, ex_valid, ex_pc, ex_instr); end
    end
    ex_ready = 1; #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%h exp=1", id_ready); end
    step();
    n_checks++; if (ex_pc !== 32'h208 || ex_imm !== 32'd7 || ex_rd !== 5'd4) begin n_fail++; $display("FAIL bp_capture pc=%h imm=%h rd=%h exp=208/7/4", ex_pc, ex_imm, ex_rd); end
  endtask

  task automatic test_flush();
    if_instr = 32'h00500093; if_pc = 32'h20C; flush = 1; #1;
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%h exp=0", id_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%h exp=0", ex_valid); end
    flush = 0; step();
    ex_ready = 0; flush = 1; step();                                  // flush under backpressure
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bp_valid got=%h exp=0", ex_valid); end
    flush = 0; ex_ready = 1; if_valid = 0; step();
  endtask

  task automatic test_writeback();
    logic [31:0] exp;
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF; step();
    wb_rd = 5'd5; wb_data = 32'h1111; step();
    wb_we = 0;
    if_valid = 1; if_instr = 32'h00000333; if_pc = 32'h300; step();   // add x6,x0,x0
    n_checks++; if (ex_rs1_data !== 32'h0) begin n_fail++; $display("FAIL wb_x0 got=%h exp=0", ex_rs1_data); end
    if_instr = 32'h00028333; wb_we = 1; wb_rd = 5'd5; wb_data = 32'h1234; step();  // add x6,x5,x0
`ifdef WB_BYPASS_EN
    exp = 32'h1234;
`else
    exp = 32'h1111;
`endif
    n_checks++; if (ex_rs1_data !== exp) begin n_fail++; $display("FAIL wb_same_cycle got=%h exp=%h", ex_rs1_data, exp); end
    wb_we = 0; step();
    n_checks++; if (ex_rs1_data !== 32'h1234) begin n_fail++; $display("FAIL wb_after got=%h exp=1234", ex_rs1_data); end
  endtask

  task automatic test_imm();
    logic [31:0] instrs [5];
    logic [31:0] imms   [5];
    instrs = '{32'hFE000CE3, 32'h123450B7, 32'hFE20AE23, 32'h010000EF, 32'h0000000B};
    imms   = '{32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFC, 32'h00000010, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      if_valid = 1; if_instr = instrs[i]; if_pc = 32'h400 + 32'(4*i); step();
      n_checks++; if (ex_valid !== 1'b1 || ex_imm !== imms[i])
        begin n_fail++; $display("FAIL imm[%0d] valid=%h imm=%h exp=1/%h", i, ex_valid, ex_imm, imms[i]); end
    end
    if_valid = 0; step();
  endtask

  task automatic test_reset_mid();
    if_valid = 1; if_instr = 32'h00028333; if_pc = 32'h500; step();
    #2 rst = 0; #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset valid=%h pc=%h exp=0/0", ex_valid, ex_pc); end
    if_valid = 0; step(); rst = 1; step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_release got=%h exp=0", ex_valid); end
    if_valid = 1; step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rf valid=%h rs1=%h exp=1/0", ex_valid, ex_rs1_data); end
    if_valid = 0; step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
    test_writeback();
    test_imm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the current decode stage: instruction decode, register file, load-use hazard detection and the ID/EX pipeline register in one block.
- Adds a valid/ready handshake in both directions, a registered ID/EX output, and a bubble/stall mechanism. The current decode stage has none of these.
- Sits between the IF/ID buffer and the execute stage. The writeback stage drives the write port.

Parameters:
- XLEN, 32, datapath width of PC, register data and immediates.
- NREG, 32, number of architectural registers. Register index width RW = $clog2(NREG). Register 0 reads as zero.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- if_valid  input  1  IF/ID holds a valid instruction.
- if_pc  input  XLEN  PC of the incoming instruction.
- if_instr  input  32  incoming instruction word.
- id_ready  output  1  the incoming instruction is consumed this cycle.
- flush  input  1  branch taken: kill the incoming instruction and the ID/EX slot.
- wb_we  input  1  register file write enable.
- wb_rd  input  RW  register file write index.
- wb_data  input  XLEN  register file write data.
- ex_ready  input  1  execute stage accepts the ID/EX contents this cycle.
- ex_valid  output  1  ID/EX slot holds a valid instruction.
- ex_pc  output  XLEN  registered PC.
- ex_instr  output  32  registered instruction word.
- ex_imm  output  XLEN  registered sign-extended immediate.
- ex_rs1_data, ex_rs2_data  output  XLEN  registered operand values.
- ex_rs1, ex_rs2, ex_rd  output  RW  registered register indices.
- ex_is_load  output  1  registered flag: opcode is LOAD.

Behaviour:
- Reset (rst=0, asynchronous): all register file entries 0. ex_valid=0. All ex_* payload outputs 0.
- Decode (combinational on if_instr):
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7], each truncated to RW bits.
  - Immediate by opcode: I-type for LOAD/OP-IMM/JALR, S-type for STORE, B-type for BRANCH, U-type for LUI/AUIPC, J-type for JAL.
  - Other opcodes get immediate 0 but still pass through as valid.
  - All immediates are sign-extended to XLEN.
- Operand use:
  - use_rs1 is true for all opcodes except LUI, AUIPC and JAL.
  - use_rs2 is true for BRANCH, STORE and OP.
- Register file:
  - Write on the rising edge when wb_we=1 and wb_rd!=0. Writes to index 0 are ignored.
  - Reads are combinational. Index 0 returns 0.
- Hazard (load-use):
  - hazard = if_valid & ex_valid & ex_is_load & (ex_rd!=0) & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- Handshake:
  - adv = !ex_valid | ex_ready.
  - id_ready = adv & !hazard & !flush.
- ID/EX register update, per rising edge, in priority order:
  1. flush=1: ex_valid<=0. The incoming instruction is dropped. Payload don't-care.
  2. else if adv: ex_valid <= if_valid & !hazard. The payload loads only when if_valid & !hazard. On a hazard, a bubble (ex_valid=0) is inserted while IF holds its instruction.
  3. else: all ex_* outputs hold.
- Latency: exactly one cycle from the accept cycle to ex_valid, with no stalls. The load-use hazard costs exactly one bubble.
- Simultaneous events:
  - Flush overrides hazard and backpressure.
  - A writeback in the same cycle as a decode read follows WB_BYPASS_EN.
- Boundary:
  - if_valid=0 with adv=1 produces ex_valid=0 next cycle.
  - ex_ready is ignored while ex_valid=0.
- Reset asserted mid-operation clears ex_valid and the register file immediately. No spurious output after reset release.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when wb_we=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), the read returns wb_data in that same cycle. ex_rs*_data therefore captures the new value.
- Undefined: the read returns the old register contents. The captured operand is stale, and the hazard/forwarding logic elsewhere must cover it.

Test Plan:
- Reset then decode: rst low→high, then if_valid=1, if_instr=0x00500093 (addi x1,x0,5), if_pc=0x100, ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rs1_data=0, ex_pc=0x100.
- Load-use: ex holds lw x2 (ex_is_load=1, ex_rd=2); if_instr=add x3,x2,x1 -> id_ready=0 for one cycle and the next ex_valid=0 (bubble). One cycle later id_ready=1 and the add enters ID/EX.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles -> id_ready=0 and all ex_* outputs stable. ex_ready=1 -> the pending instruction is captured on the following edge.
- Flush: flush=1 while if_valid=1 and ex_valid=1 -> id_ready=0 and next-cycle ex_valid=0.
- Writeback/x0: wb_we=1, wb_rd=0, wb_data=0xDEADBEEF, then read x0 -> 0. Same-cycle write x5=0x1234 while decoding add x6,x5,x0 -> ex_rs1_data=0x1234 with WB_BYPASS_EN defined, previous value without it.
- Immediate: beq with imm -8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8. lui 0x12345 -> ex_imm=0x12345000.
